// File: rtl/l15_resp_model.sv
// L1.5 responder: accepts load/ifill/store requests into an in-order queue and returns
// them from a 32B-row backing store once each has aged the minimum latency.
module l15_resp_model #(
    parameter int MEM_ROWS   = 1024,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_l,
    input  logic         req_val_i,
    input  logic [2:0]   req_rqtype_i,
    input  logic [2:0]   req_size_i,
    input  logic         req_threadid_i,
    input  logic [39:0]  req_address_i,
    input  logic [63:0]  req_data_i,
    output logic         req_header_ack_o,
    output logic         rtrn_val_o,
    output logic [3:0]   rtrn_type_o,
    output logic         rtrn_threadid_o,
    output logic [255:0] rtrn_data_o,
    input  logic         rtrn_ack_i
);
    localparam int ROW_W = $clog2(MEM_ROWS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);
    localparam logic [AGE_W-1:0] AGE_RDY = AGE_W'(LATENCY - 1);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   PTR_TWO = (PTR_W + 1)'(2);
    localparam logic [PTR_W:0]   FULL_XOR = {1'b1, {PTR_W{1'b0}}};

    localparam logic [2:0] RQ_LOAD  = 3'b000;
    localparam logic [2:0] RQ_STORE = 3'b001;
    localparam logic [2:0] RQ_IFILL = 3'b010;
    localparam logic [3:0] RT_LOAD  = 4'b0000;
    localparam logic [3:0] RT_IFILL = 4'b0001;
    localparam logic [3:0] RT_STACK = 4'b0100;
    localparam logic [3:0] RT_ERR   = 4'b1111;

    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state, state_nxt;

    logic [255:0]     mem    [MEM_ROWS];
    logic [3:0]       q_type [FIFO_DEPTH];
    logic             q_tid  [FIFO_DEPTH];
    logic [255:0]     q_data [FIFO_DEPTH];
    logic [AGE_W-1:0] q_age  [FIFO_DEPTH];

    logic [PTR_W:0]   wr_ptr, rd_ptr, count;
    logic [PTR_W-1:0] wr_idx, rd_idx, nxt_idx;
    logic             full, empty, accept, pop, head_rdy, next_rdy;
    logic [ROW_W-1:0] row_idx;
    logic [255:0]     row_rd, ent_data, wdata;
    logic [3:0]       ent_type;
    logic [31:0]      wmask;
    logic             unused_addr;

    // Byte-enable over the 32B row: 16B and wider codes collapse to 8B, address aligned down.
    function automatic logic [31:0] store_mask(input logic [2:0] size, input logic [4:0] addr);
        logic [7:0] lanes;
        logic [2:0] off;
        case (size)
            3'b000:  begin lanes = 8'h01; off = addr[2:0];          end
            3'b001:  begin lanes = 8'h03; off = {addr[2:1], 1'b0};  end
            3'b010:  begin lanes = 8'h0F; off = {addr[2], 2'b00};   end
            default: begin lanes = 8'hFF; off = 3'b000;             end
        endcase
        return {24'b0, lanes} << {addr[4:3], off};
    endfunction

    assign wr_idx  = wr_ptr[PTR_W-1:0];
    assign rd_idx  = rd_ptr[PTR_W-1:0];
    assign nxt_idx = rd_idx + PTR_W'(1);
    assign count   = wr_ptr - rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == FULL_XOR;
    assign empty   = wr_ptr == rd_ptr;
    assign accept  = req_val_i & ~full;
    assign pop     = (state == PRESENT) & rtrn_ack_i;
    assign req_header_ack_o = accept;

    assign row_idx     = req_address_i[5 +: ROW_W];
    assign row_rd      = mem[row_idx];
    assign wmask       = store_mask(req_size_i, req_address_i[4:0]);
    assign wdata       = {4{req_data_i}};
    assign unused_addr = ^req_address_i[39:5+ROW_W];

    // An entry is judged one cycle ahead so it is presented in the cycle its age reaches LATENCY.
    assign head_rdy = ~empty & (q_age[rd_idx] >= AGE_RDY);
    assign next_rdy = (count >= PTR_TWO) & (q_age[nxt_idx] >= AGE_RDY);

    always_comb begin
        ent_type = RT_ERR;
        ent_data = '0;
        case (req_rqtype_i)
            RQ_LOAD: begin
                ent_type = RT_LOAD;
                ent_data = {128'b0, req_address_i[4] ? row_rd[255:128] : row_rd[127:0]};
            end
            RQ_IFILL: begin
                ent_type = RT_IFILL;
                ent_data = row_rd;
            end
            RQ_STORE: ent_type = RT_STACK;
            default:  ent_type = RT_ERR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (accept && req_rqtype_i == RQ_STORE) begin
            for (int b = 0; b < 32; b++) begin
                if (wmask[b]) mem[row_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            q_type[wr_idx] <= ent_type;
            q_tid[wr_idx]  <= req_threadid_i;
            q_data[wr_idx] <= ent_data;
        end
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) q_age[i] <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (accept && wr_idx == PTR_W'(i)) q_age[i] <= AGE_ONE;
                else if (q_age[i] != AGE_MAX)      q_age[i] <= q_age[i] + AGE_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (head_rdy) state_nxt = PRESENT;
            PRESENT: if (rtrn_ack_i) state_nxt = next_rdy ? PRESENT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The head slot is not rewritten until popped, so presenting it directly keeps the fields stable.
    always_comb begin
        rtrn_val_o      = 1'b0;
        rtrn_type_o     = '0;
        rtrn_threadid_o = 1'b0;
        rtrn_data_o     = '0;
        if (state == PRESENT) begin
            rtrn_val_o      = 1'b1;
            rtrn_type_o     = q_type[rd_idx];
            rtrn_threadid_o = q_tid[rd_idx];
            rtrn_data_o     = q_data[rd_idx];
        end
    end
endmodule
